unlock_key_sequencer: RTL and testbench

Initiator side of the power-on lock interface. It accepts a stream of key words over a valid/ready handshake and checks them in order against a fixed key sequence. On a full match it drives a single-cycle unlock pulse into the lock register. Mismatches cost an attempt and impose a penalty wait. When attempts run out, the block refuses further keys until reset.

---
 rtl/unlock_key_sequencer_pkg.sv | 31 +++
 rtl/unlock_key_sequencer_timer.sv | 27 ++
 rtl/unlock_key_sequencer.sv | 175 +++++++++++++++++
 tb/tb_unlock_key_sequencer.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/unlock_key_sequencer_pkg.sv
// rtl/unlock_key_sequencer_pkg.sv - shared types, defaults and width helpers for the unlock key sequencer
package unlock_seq_pkg;

   localparam int                KEY_W_DEF     = 8;
   localparam int                KEY_N_DEF     = 4;
   localparam logic [31:0]       KEY_VALUE_DEF = 32'hA5C3_0F5A;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      COLLECT = 3'd1,
      UNLOCK  = 3'd2,
      DONE    = 3'd3,
      PENALTY = 3'd4,
      BRICKED = 3'd5
   } seq_state_t;

   // Width of a counter that must hold values 0..max_val.
   function automatic int cnt_w(input int max_val);
      return (max_val < 2) ? 1 : $clog2(max_val + 1);
   endfunction

   // Width of an index that addresses n entries.
   function automatic int idx_w(input int n);
      return (n < 3) ? 1 : $clog2(n);
   endfunction

   function automatic int max_of(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/unlock_key_sequencer_timer.sv
// rtl/unlock_key_sequencer_timer.sv - loadable down-counter that saturates at zero
module seq_down_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_load,
   input  logic [W-1:0] i_load_val,
   input  logic         i_en,
   output logic         o_zero
);

   logic [W-1:0] r_count;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_count <= '0;
      end else if (i_load) begin
         r_count <= i_load_val;
      end else if (i_en && (r_count != '0)) begin
         r_count <= r_count - W'(1);
      end
   end

   assign o_zero = (r_count == '0);

endmodule

// File: rtl/unlock_key_sequencer.sv
// rtl/unlock_key_sequencer.sv - key sequence checker driving a one-cycle unlock pulse
// Optional inter-key timeout in COLLECT enabled by defining UNLOCK_SEQ_TIMEOUT_EN.
module unlock_key_sequencer
   import unlock_seq_pkg::*;
#(
   parameter int                      KEY_W          = KEY_W_DEF,
   parameter int                      KEY_N          = KEY_N_DEF,
   parameter logic [KEY_N*KEY_W-1:0]  KEY_VALUE      = KEY_VALUE_DEF,
   parameter int                      MAX_ATTEMPTS   = 3,
   parameter int                      PENALTY_CYCLES = 16,
   parameter int                      TIMEOUT_CYCLES = 64
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             key_valid,
   input  logic [KEY_W-1:0]                 key_data,
   output logic                             key_ready,
   input  logic                             locked_in,
   output logic                             unlock,
   output logic                             busy,
   output logic                             fail,
   output logic [cnt_w(MAX_ATTEMPTS)-1:0]   attempts_left
);

   localparam int AW    = cnt_w(MAX_ATTEMPTS);
   localparam int IW    = idx_w(KEY_N);
   localparam int TW    = cnt_w(max_of(PENALTY_CYCLES, TIMEOUT_CYCLES));
   localparam logic [IW-1:0] LAST_IDX = IW'(KEY_N - 1);

   seq_state_t     r_state;
   logic [IW-1:0]  r_idx;
   logic [AW-1:0]  r_attempts;
   logic           r_key_ready;
   logic           r_unlock;
   logic           r_busy;
   logic           r_fail;

   logic [KEY_W-1:0] w_expected;
   logic             w_accept;
   logic             w_match;
   logic             w_tmr_load;
   logic [TW-1:0]    w_tmr_val;
   logic             w_tmr_en;
   logic             w_tmr_zero;

   always_comb begin
      w_expected = '0;
      for (int i = 0; i < KEY_N; i++) begin
         if (r_idx == IW'(i)) w_expected = KEY_VALUE[i*KEY_W +: KEY_W];
      end
   end

   assign w_accept = key_valid && r_key_ready;
   assign w_match  = (key_data == w_expected);

   // One timer serves both the penalty wait and the inter-key timeout.
   always_comb begin
      w_tmr_load = 1'b0;
      w_tmr_val  = '0;
      w_tmr_en   = 1'b0;
      case (r_state)
         IDLE, COLLECT: begin
            if (locked_in && w_accept) begin
               if (!w_match) begin
                  w_tmr_load = 1'b1;
                  w_tmr_val  = TW'(PENALTY_CYCLES - 1);
               end
`ifdef UNLOCK_SEQ_TIMEOUT_EN
               else if (r_idx != LAST_IDX) begin
                  w_tmr_load = 1'b1;
                  w_tmr_val  = TW'(TIMEOUT_CYCLES - 1);
               end
            end else if (r_state == COLLECT) begin
               w_tmr_en = 1'b1;
`endif
            end
         end
         PENALTY: w_tmr_en = 1'b1;
         default: ;
      endcase
   end

   seq_down_timer #(
      .W (TW)
   ) u_timer (
      .clk        (clk),
      .reset      (reset),
      .i_load     (w_tmr_load),
      .i_load_val (w_tmr_val),
      .i_en       (w_tmr_en),
      .o_zero     (w_tmr_zero)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         r_idx       <= '0;
         r_attempts  <= AW'(MAX_ATTEMPTS);
         r_key_ready <= locked_in;
         r_unlock    <= 1'b0;
         r_busy      <= 1'b0;
         r_fail      <= 1'b0;
      end else begin
         case (r_state)
            IDLE, COLLECT: begin
               // A lock opened elsewhere retires the block without a pulse.
               if (!locked_in) begin
                  r_state     <= DONE;
                  r_idx       <= '0;
                  r_key_ready <= 1'b0;
                  r_busy      <= 1'b0;
               end else if (w_accept) begin
                  if (w_match && (r_idx == LAST_IDX)) begin
                     r_state     <= UNLOCK;
                     r_idx       <= '0;
                     r_unlock    <= 1'b1;
                     r_key_ready <= 1'b0;
                     r_busy      <= 1'b0;
                  end else if (w_match) begin
                     r_state <= COLLECT;
                     r_idx   <= r_idx + IW'(1);
                     r_busy  <= 1'b1;
                  end else begin
                     r_idx       <= '0;
                     r_key_ready <= 1'b0;
                     if (r_attempts > AW'(1)) begin
                        r_state    <= PENALTY;
                        r_attempts <= r_attempts - AW'(1);
                        r_busy     <= 1'b1;
                     end else begin
                        r_state    <= BRICKED;
                        r_attempts <= '0;
                        r_fail     <= 1'b1;
                        r_busy     <= 1'b0;
                     end
                  end
               end
`ifdef UNLOCK_SEQ_TIMEOUT_EN
               else if ((r_state == COLLECT) && w_tmr_zero) begin
                  r_state <= IDLE;
                  r_idx   <= '0;
                  r_busy  <= 1'b0;
               end
`endif
            end
            PENALTY: begin
               if (w_tmr_zero) begin
                  r_state     <= IDLE;
                  r_key_ready <= 1'b1;
                  r_busy      <= 1'b0;
               end
            end
            UNLOCK: begin
               r_state  <= DONE;
               r_unlock <= 1'b0;
            end
            DONE, BRICKED: ;
            default: begin
               r_state     <= IDLE;
               r_idx       <= '0;
               r_key_ready <= 1'b0;
               r_unlock    <= 1'b0;
               r_busy      <= 1'b0;
            end
         endcase
      end
   end

   assign key_ready     = r_key_ready;
   assign unlock        = r_unlock;
   assign busy          = r_busy;
   assign fail          = r_fail;
   assign attempts_left = r_attempts;

endmodule

// File: tb/tb_unlock_key_sequencer.sv
// tb/tb_unlock_key_sequencer.sv - directed self-checking bench for unlock_key_sequencer
module tb_unlock_key_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       key_valid;
   logic [7:0] key_data;
   logic       key_ready;
   logic       locked_in;
   logic       unlock;
   logic       busy;
   logic       fail;
   logic [1:0] attempts_left;

   int checks = 0;
   int errors = 0;
   int n;

   always #5 clk = ~clk;

   unlock_key_sequencer dut (
      .clk           (clk),
      .reset         (reset),
      .key_valid     (key_valid),
      .key_data      (key_data),
      .key_ready     (key_ready),
      .locked_in     (locked_in),
      .unlock        (unlock),
      .busy          (busy),
      .fail          (fail),
      .attempts_left (attempts_left)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset     = 1'b1;
      key_valid = 1'b0;
      key_data  = 8'h00;
      locked_in = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   // Offers a key, waits (bounded) for ready, then returns just after the handshake edge.
   task automatic send_key(input logic [7:0] d);
      int w;
      key_valid = 1'b1;
      key_data  = d;
      w = 0;
      while (!key_ready && w < 200) begin
         step();
         w++;
      end
      if (w >= 200) chk("ready_timeout", 32'(w), 32'd0);
      step();
   endtask

   initial begin
      // 1: correct sequence back-to-back
      do_reset();
      chk("rst_ready", key_ready, 1);
      chk("rst_unlock", unlock, 0);
      chk("rst_busy", busy, 0);
      chk("rst_fail", fail, 0);
      chk("rst_attempts", attempts_left, 3);
      send_key(8'h5A);
      chk("t1_busy", busy, 1);
      send_key(8'h0F);
      send_key(8'hC3);
      send_key(8'hA5);
      chk("t1_unlock", unlock, 1);
      chk("t1_ready0", key_ready, 0);
      chk("t1_attempts", attempts_left, 3);
      step();
      chk("t1_unlock_off", unlock, 0);
      chk("t1_ready_done", key_ready, 0);
      key_data = 8'h5A;
      step();
      step();
      chk("t1_done_hold", key_ready, 0);
      chk("t1_done_unlock", unlock, 0);
      key_valid = 1'b0;

      // 2: mismatch, penalty length, then recovery
      do_reset();
      send_key(8'h5A);
      send_key(8'h0F);
      send_key(8'h00);
      key_valid = 1'b0;
      chk("t2_attempts", attempts_left, 2);
      chk("t2_busy", busy, 1);
      n = 0;
      while (!key_ready && n < 100) begin
         n++;
         step();
      end
      chk("t2_penalty_len", 32'(n), 16);
      chk("t2_busy_after", busy, 0);
      send_key(8'h5A);
      send_key(8'h0F);
      send_key(8'hC3);
      send_key(8'hA5);
      key_valid = 1'b0;
      chk("t2_unlock", unlock, 1);
      chk("t2_attempts_end", attempts_left, 2);

      // 3: exhaust attempts
      do_reset();
      send_key(8'h11);
      chk("t3_att2", attempts_left, 2);
      send_key(8'h22);
      chk("t3_att1", attempts_left, 1);
      send_key(8'h33);
      chk("t3_fail", fail, 1);
      chk("t3_att0", attempts_left, 0);
      chk("t3_busy", busy, 0);
      key_data = 8'h5A;
      n = 0;
      for (int i = 0; i < 200; i++) begin
         if (key_ready || unlock) n++;
         step();
      end
      chk("t3_bricked_hold", 32'(n), 0);
      chk("t3_fail_sticky", fail, 1);
      key_valid = 1'b0;

      // 4: reset coincides with the final key
      do_reset();
      send_key(8'h5A);
      send_key(8'h0F);
      send_key(8'hC3);
      key_data = 8'hA5;
      reset    = 1'b1;
      step();
      reset     = 1'b0;
      key_valid = 1'b0;
      chk("t4_unlock", unlock, 0);
      chk("t4_ready", key_ready, 1);
      chk("t4_attempts", attempts_left, 3);
      chk("t4_busy", busy, 0);
      step();
      chk("t4_unlock_late", unlock, 0);

      // 5: lock already open
      do_reset();
      locked_in = 1'b0;
      step();
      chk("t5_ready", key_ready, 0);
      chk("t5_attempts", attempts_left, 3);
      locked_in = 1'b1;
      key_valid = 1'b1;
      key_data  = 8'h5A;
      n = 0;
      for (int i = 0; i < 10; i++) begin
         if (key_ready || unlock) n++;
         step();
      end
      chk("t5_done_hold", 32'(n), 0);
      key_valid = 1'b0;

      // 6: long gap inside a sequence
      do_reset();
      send_key(8'h5A);
      send_key(8'h0F);
      key_valid = 1'b0;
      for (int i = 0; i < 63; i++) step();
      chk("t6_busy_63", busy, 1);
      step();
`ifdef UNLOCK_SEQ_TIMEOUT_EN
      chk("t6_busy_64", busy, 0);
      send_key(8'h5A);
      send_key(8'h0F);
`else
      chk("t6_busy_64", busy, 1);
`endif
      send_key(8'hC3);
      send_key(8'hA5);
      key_valid = 1'b0;
      chk("t6_unlock", unlock, 1);
      chk("t6_attempts", attempts_left, 3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
